// File: rtl/mem_filter_pingpong.sv
// mem_filter_pingpong
//   Ping-pong filter-weight memory. The loader fills one bank while the compute
//   array reads the other. Ownership of a bank moves on commit (last accepted
//   write beat) and release (rd_done_i). Read data is registered, 1-cycle latency.
//
//   Ports
//     clk_i, rst_n_i          clock, async active-low reset
//     wr_*                    write beat: valid/ready, sparsemap, nonzero bytes,
//                             beat/chunk index, last (commits the write bank)
//     rd_avail_o              read bank holds committed data
//     rd_req_i, rd_*_count_i  read request and beat/chunk index
//     rd_valid_o, rd_*_o      registered read beat
//     rd_done_i               release the read bank
//     bank_full_o             per-bank committed flags
//
//   Optional: define MEM_FILTER_POPCNT_EN to add rd_popcnt_o, the number of
//   ones in the returned sparsemap beat (= valid nonzero bytes in the beat).
module mem_filter_pingpong #(
   parameter  int BUS_SIZE    = 32,
   parameter  int MEM_SIZE    = 128,
   parameter  int FILTER_NUM  = 64,
   localparam int DAT_CYC_NUM = MEM_SIZE / BUS_SIZE,
   localparam int DW          = (DAT_CYC_NUM > 1) ? $clog2(DAT_CYC_NUM) : 1,
   localparam int CW          = (FILTER_NUM > 1) ? $clog2(FILTER_NUM) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [BUS_SIZE-1:0]   wr_sparsemap_i,
   input  logic [BUS_SIZE*8-1:0] wr_nonzero_data_i,
   input  logic [DW-1:0]         wr_dat_count_i,
   input  logic [CW-1:0]         wr_chunk_count_i,
   input  logic                  wr_last_i,
   output logic                  rd_avail_o,
   input  logic                  rd_req_i,
   input  logic [DW-1:0]         rd_dat_count_i,
   input  logic [CW-1:0]         rd_chunk_count_i,
   output logic                  rd_valid_o,
   output logic [BUS_SIZE-1:0]   rd_sparsemap_o,
   output logic [BUS_SIZE*8-1:0] rd_nonzero_data_o,
`ifdef MEM_FILTER_POPCNT_EN
   output logic [$clog2(BUS_SIZE+1)-1:0] rd_popcnt_o,
`endif
   input  logic                  rd_done_i,
   output logic [1:0]            bank_full_o
);

   // Storage is deliberately not reset; contents are undefined until written.
   logic [BUS_SIZE-1:0]   sm_mem [2][FILTER_NUM][DAT_CYC_NUM];
   logic [BUS_SIZE*8-1:0] nz_mem [2][FILTER_NUM][DAT_CYC_NUM];

   logic       wr_bank, rd_bank;
   logic [1:0] bank_full;

   logic wr_acc, commit, rd_go, release_go, wr_in_range, rd_in_range;

   assign wr_ready_o  = ~bank_full[wr_bank];
   assign rd_avail_o  = bank_full[rd_bank];
   assign bank_full_o = bank_full;

   assign wr_acc     = wr_valid_i & wr_ready_o;
   assign commit     = wr_acc & wr_last_i;
   assign rd_go      = rd_req_i & rd_avail_o;
   assign release_go = rd_done_i & rd_avail_o;

   assign wr_in_range = (int'(wr_chunk_count_i) < FILTER_NUM) &&
                        (int'(wr_dat_count_i) < DAT_CYC_NUM);
   assign rd_in_range = (int'(rd_chunk_count_i) < FILTER_NUM) &&
                        (int'(rd_dat_count_i) < DAT_CYC_NUM);

   // Out-of-range beats are dropped; wr_last_i still commits below.
   always_ff @(posedge clk_i) begin
      if (wr_acc && wr_in_range) begin
         sm_mem[wr_bank][wr_chunk_count_i][wr_dat_count_i] <= wr_sparsemap_i;
         nz_mem[wr_bank][wr_chunk_count_i][wr_dat_count_i] <= wr_nonzero_data_i;
      end
   end

   // Commit needs bank_full[wr_bank]=0 and release needs bank_full[rd_bank]=1,
   // so when both fire they always target different banks and both apply.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         bank_full <= 2'b00;
      end else begin
         bank_full <= (bank_full | (commit ? (2'b01 << wr_bank) : 2'b00))
                    & ~(release_go ? (2'b01 << rd_bank) : 2'b00);
         if (commit)     wr_bank <= ~wr_bank;
         if (release_go) rd_bank <= ~rd_bank;
      end
   end

   // Read mux uses the pre-toggle rd_bank, so a read issued with rd_done_i
   // returns data from the bank being released. Memory writes land at the same
   // edge, so a write in this cycle is never visible to this read.
   logic [BUS_SIZE-1:0]   rd_sm_mux;
   logic [BUS_SIZE*8-1:0] rd_nz_mux;

   always_comb begin
      rd_sm_mux = '0;
      rd_nz_mux = '0;
      if (rd_in_range) begin
         rd_sm_mux = sm_mem[rd_bank][rd_chunk_count_i][rd_dat_count_i];
         rd_nz_mux = nz_mem[rd_bank][rd_chunk_count_i][rd_dat_count_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_valid_o        <= 1'b0;
         rd_sparsemap_o    <= '0;
         rd_nonzero_data_o <= '0;
      end else begin
         rd_valid_o <= rd_go;
         if (rd_go) begin
            rd_sparsemap_o    <= rd_sm_mux;
            rd_nonzero_data_o <= rd_nz_mux;
         end
      end
   end

`ifdef MEM_FILTER_POPCNT_EN
   localparam int PW = $clog2(BUS_SIZE+1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)   rd_popcnt_o <= '0;
      else if (rd_go) rd_popcnt_o <= PW'($countones(rd_sm_mux));
   end
`endif

endmodule
